// File: rtl/i2c_txn_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_txn_arbiter
//
// Shares one I2C master FSM (sda_generate) between NUM_REQ requesters.
// A round-robin arbiter picks an owner and latches that owner's transaction
// description onto the master's configuration inputs. It then pulses start,
// watches the master's state to classify the outcome, and hands a done pulse
// plus an error code back to the owner.
//
// Requester handshake: req[i] is a level. The requester raises it with its
// addr/rw/data/ack_more lines valid and holds them until done[i] pulses for
// one cycle. grant[i] marks ownership from the cycle after arbitration up to
// and including the done cycle. The data lines are sampled only once, in the
// LOAD cycle, so they need only be valid until grant[i] rises plus one cycle.
// Dropping req mid-transaction does not abort it.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req             per-requester request level
//   req_addr        packed slave addresses, requester i at [i*ADDR_LEN +: ADDR_LEN]
//   req_rw          1 = read, 0 = write
//   req_data1/2     packed first/second write bytes
//   req_ack_more    read: 1 = master ACKs the first byte and continues
//   grant           one-hot owner, 0 when idle
//   done            one-cycle completion pulse to the owner
//   err_code        00 ok, 01 addr NACK, 10 data NACK, 11 timeout (held)
//   m_start         one-cycle start pulse to the master
//   m_add_reg, m_rw, m_data_1, m_data_2, m_ack_3p   master configuration
//   m_free          master idle flag
//   m_state         master state code
//   fsm_state       current arbiter state (observation only)
// -----------------------------------------------------------------------------
module i2c_txn_arbiter #(
   parameter int NUM_REQ       = 2,
   parameter int ADDR_LEN      = 7,
   parameter int DATA_LEN      = 8,
   parameter int START_TIMEOUT = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
   input  logic [NUM_REQ-1:0]           req_rw,
   input  logic [NUM_REQ*DATA_LEN-1:0]  req_data1,
   input  logic [NUM_REQ*DATA_LEN-1:0]  req_data2,
   input  logic [NUM_REQ-1:0]           req_ack_more,
   output logic [NUM_REQ-1:0]           grant,
   output logic [NUM_REQ-1:0]           done,
   output logic [1:0]                   err_code,
   output logic                         m_start,
   output logic [ADDR_LEN-1:0]          m_add_reg,
   output logic                         m_rw,
   output logic [DATA_LEN-1:0]          m_data_1,
   output logic [DATA_LEN-1:0]          m_data_2,
   output logic                         m_ack_3p,
   input  logic                         m_free,
   input  logic [3:0]                   m_state,
   output logic [2:0]                   fsm_state
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

   // Master state codes that matter for outcome classification.
   localparam logic [3:0] MS_CHK_ACK_DATA = 4'h5;
   localparam logic [3:0] MS_STOP         = 4'hB;
   localparam logic [3:0] MS_CHK_ACK_ADDR = 4'hC;

   typedef enum logic [2:0] {
      S_ARB       = 3'd0,
      S_LOAD      = 3'd1,
      S_LAUNCH    = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_RUN       = 3'd4,
      S_REPORT    = 3'd5
   } state_t;

   state_t               state, state_nxt;
   logic [PW-1:0]        owner;
   logic [PW-1:0]        rr_ptr;
   logic [TW-1:0]        timer;
   logic [3:0]           prev_state;
   logic [1:0]           data_ack_cnt, cnt_nxt;
   logic [1:0]           run_err, err_nxt;
   logic                 pick_found;
   logic [PW-1:0]        pick_idx;
   logic [NUM_REQ-1:0]   pick_onehot;

   assign fsm_state = state;

   // Round-robin pick: scan offsets from the top down so the smallest
   // offset from rr_ptr with a set request is the one that sticks.
   always_comb begin
      int idx;
      idx         = 0;
      pick_found  = 1'b0;
      pick_idx    = '0;
      pick_onehot = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = (int'(rr_ptr) + i) % NUM_REQ;
         if (req[idx]) begin
            pick_found = 1'b1;
            pick_idx   = PW'(idx);
         end
      end
      pick_onehot[pick_idx] = 1'b1;
   end

   // Outcome tracking while the master runs. prev_state is sampled every
   // cycle, so transitions are seen as (prev_state -> m_state) pairs.
   always_comb begin
      cnt_nxt = data_ack_cnt;
      err_nxt = run_err;
      if (state == S_RUN) begin
         if (m_state == MS_CHK_ACK_DATA && prev_state != MS_CHK_ACK_DATA &&
             data_ack_cnt != 2'b11)
            cnt_nxt = data_ack_cnt + 2'b01;
         if (prev_state == MS_CHK_ACK_ADDR && m_state == MS_STOP)
            err_nxt = 2'b01;
         else if (prev_state == MS_CHK_ACK_DATA && m_state == MS_STOP &&
                  data_ack_cnt == 2'b01 && !m_rw)
            // Stop straight after the first data ACK slot of a write means
            // the slave refused the first byte.
            err_nxt = 2'b10;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_ARB:       if (pick_found && m_free) state_nxt = S_LOAD;
         S_LOAD:      state_nxt = S_LAUNCH;
         S_LAUNCH:    state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (!m_free)               state_nxt = S_RUN;
            else if (timer == TMO_LAST) state_nxt = S_REPORT;
         end
         // RUN is only entered with m_free low, so any high level is a rise.
         S_RUN:       if (m_free) state_nxt = S_REPORT;
         S_REPORT:    state_nxt = S_ARB;
         default:     state_nxt = S_ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_ARB;
         owner        <= '0;
         rr_ptr       <= '0;
         timer        <= '0;
         prev_state   <= '0;
         data_ack_cnt <= '0;
         run_err      <= '0;
         grant        <= '0;
         done         <= '0;
         err_code     <= '0;
         m_start      <= 1'b0;
         m_add_reg    <= '0;
         m_rw         <= 1'b0;
         m_data_1     <= '0;
         m_data_2     <= '0;
         m_ack_3p     <= 1'b0;
      end else begin
         state      <= state_nxt;
         prev_state <= m_state;
         case (state)
            S_ARB: begin
               if (state_nxt == S_LOAD) begin
                  grant <= pick_onehot;
                  owner <= pick_idx;
               end
            end
            S_LOAD: begin
               m_add_reg    <= req_addr[int'(owner)*ADDR_LEN +: ADDR_LEN];
               m_rw         <= req_rw[owner];
               m_data_1     <= req_data1[int'(owner)*DATA_LEN +: DATA_LEN];
               m_data_2     <= req_data2[int'(owner)*DATA_LEN +: DATA_LEN];
               m_ack_3p     <= req_ack_more[owner];
               data_ack_cnt <= '0;
               run_err      <= '0;
               m_start      <= 1'b1;
            end
            S_LAUNCH: begin
               m_start <= 1'b0;
               timer   <= '0;
            end
            S_WAIT_BUSY: begin
               timer <= timer + 1'b1;
               if (state_nxt == S_REPORT) begin
                  done     <= grant;
                  err_code <= 2'b11;
               end
            end
            S_RUN: begin
               data_ack_cnt <= cnt_nxt;
               run_err      <= err_nxt;
               if (state_nxt == S_REPORT) begin
                  done     <= grant;
                  err_code <= err_nxt;
               end
            end
            S_REPORT: begin
               done   <= '0;
               grant  <= '0;
               rr_ptr <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for i2c_txn_arbiter. A scripted master emulator plays back a list of
// master state codes after each start pulse. A transaction-level model keeps
// the expected owner (rotating priority), expected configuration and expected
// error code (derived from the scripted state sequence), and one compare
// process checks the DUT against it on every cycle.
// -----------------------------------------------------------------------------
module tb_i2c_txn_arbiter;

   localparam int NUM_REQ       = 2;
   localparam int ADDR_LEN      = 7;
   localparam int DATA_LEN      = 8;
   localparam int START_TIMEOUT = 64;

   logic                        clk;
   logic                        rst_n;
   logic [NUM_REQ-1:0]          req;
   logic [NUM_REQ*ADDR_LEN-1:0] req_addr;
   logic [NUM_REQ-1:0]          req_rw;
   logic [NUM_REQ*DATA_LEN-1:0] req_data1;
   logic [NUM_REQ*DATA_LEN-1:0] req_data2;
   logic [NUM_REQ-1:0]          req_ack_more;
   logic [NUM_REQ-1:0]          grant;
   logic [NUM_REQ-1:0]          done;
   logic [1:0]                  err_code;
   logic                        m_start;
   logic [ADDR_LEN-1:0]         m_add_reg;
   logic                        m_rw;
   logic [DATA_LEN-1:0]         m_data_1;
   logic [DATA_LEN-1:0]         m_data_2;
   logic                        m_ack_3p;
   logic                        m_free;
   logic [3:0]                  m_state;
   logic [2:0]                  fsm_state;

   // per-requester stimulus
   logic [ADDR_LEN-1:0] a_arr  [NUM_REQ];
   logic [DATA_LEN-1:0] d1_arr [NUM_REQ];
   logic [DATA_LEN-1:0] d2_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
      assign req_addr[g*ADDR_LEN +: ADDR_LEN]  = a_arr[g];
      assign req_data1[g*DATA_LEN +: DATA_LEN] = d1_arr[g];
      assign req_data2[g*DATA_LEN +: DATA_LEN] = d2_arr[g];
   end

   i2c_txn_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN),
      .START_TIMEOUT(START_TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
      .req_data1(req_data1), .req_data2(req_data2), .req_ack_more(req_ack_more),
      .grant(grant), .done(done), .err_code(err_code), .m_start(m_start),
      .m_add_reg(m_add_reg), .m_rw(m_rw), .m_data_1(m_data_1), .m_data_2(m_data_2),
      .m_ack_3p(m_ack_3p), .m_free(m_free), .m_state(m_state), .fsm_state(fsm_state)
   );

   // ---------------- clock / reset / counters ----------------
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- scripted master emulator ----------------
   logic [3:0] script [$];
   logic [3:0] run_seq [$];
   logic       force_free;
   bit         em_busy;
   int         em_pos;

   initial begin
      m_free  = 1'b1;
      m_state = 4'h0;
      em_busy = 1'b0;
      em_pos  = 0;
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            m_free  = 1'b1;
            m_state = 4'h0;
            em_busy = 1'b0;
         end else if (em_busy) begin
            if (em_pos < run_seq.size()) begin
               m_state = run_seq[em_pos];
               em_pos++;
            end else begin
               m_free  = 1'b1;
               m_state = 4'h0;
               em_busy = 1'b0;
            end
         end else if (m_start && !force_free) begin
            run_seq = script;
            m_free  = 1'b0;
            m_state = run_seq[0];
            em_pos  = 1;
            em_busy = 1'b1;
         end
      end
   end

   // ---------------- model ----------------
   // Outcome from a complete state sequence: a Stop straight after the address
   // ACK check is an address NACK; a Stop straight after the first data ACK
   // check of a write is a data NACK; anything else is OK.
   function automatic logic [1:0] model_err(input logic rw);
      int n5;
      n5 = 0;
      for (int i = 1; i < script.size(); i++)
         if (script[i-1] == 4'hC && script[i] == 4'hB) return 2'b01;
      for (int i = 0; i < script.size(); i++) begin
         if (script[i] == 4'h5 && (i == 0 || script[i-1] != 4'h5)) n5++;
         if (i > 0 && script[i] == 4'hB && script[i-1] == 4'h5 && n5 == 1 && !rw)
            return 2'b10;
      end
      return 2'b00;
   endfunction

   function automatic int model_pick(input logic [NUM_REQ-1:0] r, input int rr);
      for (int k = 0; k < NUM_REQ; k++)
         if (r[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
      return 0;
   endfunction

   logic [1:0]         exp_q [$];
   logic [NUM_REQ-1:0] grant_hist [$];
   int                 rr_model = 0;
   int                 cur_owner = 0;
   logic [NUM_REQ-1:0] prev_grant = '0;
   logic [NUM_REQ-1:0] prev_done = '0;
   logic               prev_start = 1'b0;
   logic [NUM_REQ-1:0] req_q = '0;
   bit                 cfg_valid = 1'b0;
   logic [ADDR_LEN-1:0] cfg_addr;
   logic [DATA_LEN-1:0] cfg_d1, cfg_d2;
   logic                cfg_rw, cfg_ack;
   int                 start_cyc = 0;
   int                 done_cyc = 0;
   int                 start_cnt = 0;
   int                 done_cnt = 0;
   logic [1:0]         last_err = '0;
   logic [NUM_REQ-1:0] last_done = '0;

   // ---------------- compare process (negedge) ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         rr_model   = 0;
         prev_grant = '0;
         prev_done  = '0;
         prev_start = 1'b0;
         req_q      = '0;
         cfg_valid  = 1'b0;
      end else begin
         if (grant != '0 && prev_grant == '0) begin
            cur_owner = model_pick(req_q, rr_model);
            chk("grant_owner", grant, 32'(1) << cur_owner);
            grant_hist.push_back(grant);
         end
         if (grant != '0 && prev_grant != '0 && grant != prev_grant)
            chk("grant_hold", grant, prev_grant);
         if (m_start) begin
            chk("start_owned", grant != '0, 1);
            chk("start_single", prev_start, 0);
            chk("cfg_addr", m_add_reg, a_arr[cur_owner]);
            chk("cfg_rw", m_rw, req_rw[cur_owner]);
            chk("cfg_d1", m_data_1, d1_arr[cur_owner]);
            chk("cfg_d2", m_data_2, d2_arr[cur_owner]);
            chk("cfg_ack", m_ack_3p, req_ack_more[cur_owner]);
            cfg_addr  = m_add_reg;
            cfg_rw    = m_rw;
            cfg_d1    = m_data_1;
            cfg_d2    = m_data_2;
            cfg_ack   = m_ack_3p;
            cfg_valid = 1'b1;
            start_cyc = cyc;
            start_cnt++;
            exp_q.push_back(force_free ? 2'b11 : model_err(req_rw[cur_owner]));
         end else if (cfg_valid && grant != '0) begin
            chk("stable", {m_add_reg, m_rw, m_data_1, m_data_2, m_ack_3p},
                {cfg_addr, cfg_rw, cfg_d1, cfg_d2, cfg_ack});
         end
         if (done != '0) begin
            chk("done_owner", done, grant);
            chk("done_single", prev_done, 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done_unexpected: got %0h expected no done", done);
            end else begin
               chk("err_code", err_code, exp_q.pop_front());
            end
            last_err  = err_code;
            last_done = done;
            done_cyc  = cyc;
            done_cnt++;
            rr_model  = (cur_owner + 1) % NUM_REQ;
            cfg_valid = 1'b0;
         end
         prev_grant = grant;
         prev_done  = done;
         prev_start = m_start;
         req_q      = req;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_done(input int budget, input string name);
      int n;
      int d0;
      n  = 0;
      d0 = done_cnt;
      while (done_cnt == d0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (done_cnt == d0) chk({name, "_done_timeout"}, 0, 1);
   endtask

   task automatic wait_start(input int budget, input string name);
      int n;
      int s0;
      n  = 0;
      s0 = start_cnt;
      while (start_cnt == s0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (start_cnt == s0) chk({name, "_start_timeout"}, 0, 1);
   endtask

   task automatic set_req(input int i, input logic [ADDR_LEN-1:0] a, input logic rw,
                          input logic [DATA_LEN-1:0] x1, input logic [DATA_LEN-1:0] x2,
                          input logic ackm);
      a_arr[i]        = a;
      req_rw[i]       = rw;
      d1_arr[i]       = x1;
      d2_arr[i]       = x2;
      req_ack_more[i] = ackm;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int c0;
      int dc;
      rst_n        = 1'b0;
      req          = '0;
      req_rw       = '0;
      req_ack_more = '0;
      force_free   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         a_arr[i]  = '0;
         d1_arr[i] = '0;
         d2_arr[i] = '0;
      end
      script = '{4'h1, 4'h2, 4'h2, 4'hC, 4'h3, 4'h3, 4'h5, 4'h3, 4'h3, 4'h5, 4'hB, 4'hB};

      idle(3);
      chk("rst_grant", grant, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_code, 0);
      chk("rst_start", m_start, 0);
      chk("rst_cfg", {m_add_reg, m_rw, m_data_1, m_data_2, m_ack_3p}, 0);
      chk("rst_state", fsm_state, 0);
      rst_n = 1'b1;
      idle(2);

      // T1: single write from requester 0, all ACKed
      set_req(0, 7'h50, 1'b0, 8'hA5, 8'h3C, 1'b0);
      set_req(1, 7'h11, 1'b0, 8'h77, 8'h88, 1'b1);
      c0  = cyc;
      req = 2'b01;
      wait_done(200, "t1");
      req = 2'b00;
      // start is visible in the third cycle, counting the ARB cycle as the first
      chk("t1_latency", 32'(start_cyc - c0), 2);
      chk("t1_err", last_err, 2'b00);
      chk("t1_done", last_done, 2'b01);
      idle(2);

      // T2: address NACK from requester 1
      set_req(1, 7'h2A, 1'b0, 8'h12, 8'h34, 1'b0);
      script = '{4'h1, 4'h2, 4'h2, 4'hC, 4'hB, 4'hB};
      req = 2'b10;
      wait_done(200, "t2");
      req = 2'b00;
      chk("t2_err", last_err, 2'b01);
      chk("t2_done", last_done, 2'b10);
      idle(2);

      // T3: data NACK on the first byte, requester 1
      script = '{4'h1, 4'h2, 4'h2, 4'hC, 4'h3, 4'h3, 4'h5, 4'hB, 4'hB};
      req = 2'b10;
      wait_done(200, "t3");
      req = 2'b00;
      chk("t3_err", last_err, 2'b10);
      idle(2);

      // T4: contention, both held; round robin must alternate starting at 0
      set_req(0, 7'h50, 1'b0, 8'hA5, 8'h3C, 1'b1);
      set_req(1, 7'h23, 1'b0, 8'h5A, 8'hC3, 1'b0);
      script = '{4'h1, 4'h2, 4'h2, 4'hC, 4'h3, 4'h3, 4'h5, 4'h3, 4'h3, 4'h5, 4'hB, 4'hB};
      grant_hist.delete();
      req = 2'b11;
      for (int k = 0; k < 4; k++) wait_done(200, "t4");
      req = 2'b00;
      idle(4);
      chk("t4_count", grant_hist.size(), 4);
      if (grant_hist.size() == 4) begin
         chk("t4_g0", grant_hist[0], 2'b01);
         chk("t4_g1", grant_hist[1], 2'b10);
         chk("t4_g2", grant_hist[2], 2'b01);
         chk("t4_g3", grant_hist[3], 2'b10);
      end

      // T5: read with ack_more=0, requester drops req mid-transaction
      set_req(1, 7'h3F, 1'b1, 8'h00, 8'h00, 1'b0);
      script = '{4'h1, 4'h2, 4'h2, 4'hC, 4'h6, 4'h6, 4'h7, 4'hB, 4'hB};
      req = 2'b10;
      wait_start(50, "t5");
      req = 2'b00;
      chk("t5_ack3p", m_ack_3p, 0);
      chk("t5_rw", m_rw, 1);
      wait_done(200, "t5");
      chk("t5_err", last_err, 2'b00);
      chk("t5_done", last_done, 2'b10);
      idle(2);

      // T6: master never leaves free -> timeout
      force_free = 1'b1;
      req = 2'b01;
      wait_done(300, "t6");
      req = 2'b00;
      chk("t6_err", last_err, 2'b11);
      // WAIT_BUSY is entered the cycle after the start pulse
      chk("t6_delay", 32'(done_cyc - (start_cyc + 1)), START_TIMEOUT);
      chk("t6_back_arb", fsm_state, 0);
      force_free = 1'b0;
      idle(2);

      // T7: reset during RUN, then a fresh request from requester 1
      script = '{4'h1, 4'h2, 4'h2, 4'hC, 4'h3, 4'h3, 4'h5, 4'h3, 4'h3, 4'h5, 4'hB, 4'hB};
      req = 2'b01;
      wait_start(50, "t7");
      idle(4);
      dc    = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("t7_rst_grant", grant, 0);
      chk("t7_rst_done", done, 0);
      chk("t7_rst_start", m_start, 0);
      chk("t7_rst_err", err_code, 0);
      chk("t7_rst_cfg", {m_add_reg, m_rw, m_data_1, m_data_2, m_ack_3p}, 0);
      req = 2'b00;
      idle(3);
      rst_n = 1'b1;
      idle(3);
      chk("t7_no_done", done_cnt, dc);
      grant_hist.delete();
      req = 2'b10;
      wait_done(200, "t7");
      req = 2'b00;
      chk("t7_hist", grant_hist.size(), 1);
      if (grant_hist.size() == 1) chk("t7_owner", grant_hist[0], 2'b10);
      chk("t7_err", last_err, 2'b00);
      idle(3);
      chk("end_exp_q_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
